photon_count_buffer: RTL and testbench

Multi-channel successor to the single 16-bit photon counter and DataMemory pair. Counts photon pulses on N_CH detector inputs per DMD pattern frame. Each frame boundary is the DMD_sig rising edge. At each boundary, all channel counts are written as whole frames into a circular word FIFO. The SPI/controller path drains the FIFO one word per request.

---
 rtl/photon_count_buffer.sv | 190 +++++++++++++++++++
 tb/tb_photon_count_buffer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/photon_count_buffer.sv
// Multi-channel photon counter: counts detector pulses per DMD frame and
// stores each completed frame as N_CH consecutive words in a circular FIFO.
module photon_count_buffer #(
  parameter int N_CH   = 2,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 10,
  parameter int CH_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   sig,
  input  logic              DMD_sig,
  input  logic              enable,
  input  logic              clear,
  input  logic              rd_req,
  output logic [CNT_W-1:0]  rd_data,
  output logic [CH_W-1:0]   rd_ch,
  output logic              rd_valid,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              sat
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, ARM, COUNT, WRITE} state_t;

  state_t state, next_state;

  logic [N_CH:0]      sync1, sync2, sync3, det;
  logic [N_CH-1:0]    pulse;
  logic               dmd_edge;

  logic [CNT_W-1:0]   cnt    [N_CH];
  logic [CNT_W-1:0]   shadow [N_CH];
  logic [CNT_W-1:0]   mem    [DEPTH];

  logic [ADDR_W-1:0]  wr_ptr, rd_ptr;
  logic [CH_W-1:0]    wr_idx, rd_ch_ptr;
  logic [ADDR_W:0]    free_words;
  logic               stop_q, has_room, counting, last_word;
  logic               wr_en, rd_en, frame_store, frame_drop, sat_set;

  // The DMD marker rides as the top bit so it sees exactly the same latency as sig.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
      det   <= '0;
    end else begin
      sync1 <= {DMD_sig, sig};
      sync2 <= sync1;
      sync3 <= sync2;
      det   <= sync2 & ~sync3;
    end
  end

  assign pulse    = det[N_CH-1:0];
  assign dmd_edge = det[N_CH];

  assign free_words  = (ADDR_W+1)'(DEPTH) - level;
  assign has_room    = free_words >= (ADDR_W+1)'(N_CH);
  assign counting    = (state == COUNT) || (state == WRITE);
  assign last_word   = wr_idx == CH_W'(N_CH-1);
  assign wr_en       = state == WRITE;
  assign rd_en       = rd_req && (level != '0);
  assign frame_store = (state == COUNT) && enable && dmd_edge && has_room;
  assign frame_drop  = dmd_edge && (((state == COUNT) && enable && !has_room) || (state == WRITE));

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (enable) next_state = ARM;
      ARM:   if (!enable) next_state = IDLE;
             else if (dmd_edge) next_state = COUNT;
      COUNT: if (!enable) next_state = IDLE;
             else if (dmd_edge && has_room) next_state = WRITE;
      WRITE: if (last_word) next_state = (stop_q || !enable) ? IDLE : COUNT;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    sat_set = 1'b0;
    for (int i = 0; i < N_CH; i++)
      if (counting && !dmd_edge && pulse[i] && (cnt[i] == '1)) sat_set = 1'b1;
  end

  // stop_q remembers an enable drop seen mid-frame so the frame still completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wr_idx <= '0;
      stop_q <= 1'b0;
    end else if (clear) begin
      state  <= IDLE;
      wr_idx <= '0;
      stop_q <= 1'b0;
    end else begin
      state  <= next_state;
      wr_idx <= (state == WRITE && !last_word) ? wr_idx + 1'b1 : '0;
      if (state != WRITE)
        stop_q <= 1'b0;
      else if (!enable)
        stop_q <= 1'b1;
    end
  end

  // A boundary zeroes every counter; a pulse in that same cycle opens the new frame at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= '0;
      end
      sat      <= 1'b0;
      overflow <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= '0;
      end
      sat      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!counting)
          cnt[i] <= '0;
        else if (dmd_edge)
          cnt[i] <= pulse[i] ? CNT_W'(1) : '0;
        else if (pulse[i] && (cnt[i] != '1))
          cnt[i] <= cnt[i] + 1'b1;
      end
      if (frame_store) begin
        for (int i = 0; i < N_CH; i++) shadow[i] <= cnt[i];
      end else if (wr_en) begin
        for (int i = 0; i < N_CH - 1; i++) shadow[i] <= shadow[i+1];
        shadow[N_CH-1] <= '0;
      end
      if (sat_set)    sat      <= 1'b1;
      if (frame_drop) overflow <= 1'b1;
    end
  end

  // Storage array is deliberately left out of reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem[wr_ptr] <= shadow[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_ch_ptr <= '0;
      level     <= '0;
      rd_data   <= '0;
      rd_ch     <= '0;
      rd_valid  <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_ch_ptr <= '0;
      level     <= '0;
      rd_data   <= '0;
      rd_ch     <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_data   <= mem[rd_ptr];
        rd_ch     <= rd_ch_ptr;
        rd_ptr    <= rd_ptr + 1'b1;
        rd_ch_ptr <= (rd_ch_ptr == CH_W'(N_CH-1)) ? '0 : rd_ch_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign empty = level == '0;
  assign full  = level == (ADDR_W+1)'(DEPTH);

endmodule

// File: tb/tb_photon_count_buffer.sv
// Self-checking bench for photon_count_buffer: small FIFO and 4-bit counters
// so saturation, full and pointer wrap are all reachable quickly.
module tb_photon_count_buffer;

  localparam int N_CH   = 2;
  localparam int CNT_W  = 4;
  localparam int ADDR_W = 2;
  localparam int CH_W   = 3;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH-1:0]   sig;
  logic              DMD_sig;
  logic              enable;
  logic              clear;
  logic              rd_req;
  logic [CNT_W-1:0]  rd_data;
  logic [CH_W-1:0]   rd_ch;
  logic              rd_valid;
  logic [ADDR_W:0]   level;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              sat;

  typedef struct {
    logic [CNT_W-1:0] data;
    logic [CH_W-1:0]  ch;
  } exp_t;

  typedef struct {
    int n0;
    int n1;
    int e0;
    int e1;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[10];
  int   checks = 0;
  int   errors = 0;
  int   exp_level = 0;

  always #10 clk = ~clk;

  photon_count_buffer #(.N_CH(N_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst), .sig(sig), .DMD_sig(DMD_sig), .enable(enable),
    .clear(clear), .rd_req(rd_req), .rd_data(rd_data), .rd_ch(rd_ch),
    .rd_valid(rd_valid), .level(level), .empty(empty), .full(full),
    .overflow(overflow), .sat(sat)
  );

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every popped word is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rd_valid: got data %0d ch %0d, expected no output", rd_data, rd_ch);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("rd_data", int'(rd_data), int'(e.data));
        check_output("rd_ch", int'(rd_ch), int'(e.ch));
      end
    end
  end

  task automatic apply_stimulus(input int n0, input int n1);
    int m;
    m = (n0 > n1) ? n0 : n1;
    for (int i = 0; i < m; i++) begin
      sig = {logic'(i < n1), logic'(i < n0)};
      repeat (2) @(negedge clk);
      sig = '0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic dmd_pulse();
    DMD_sig = 1'b1;
    repeat (2) @(negedge clk);
    DMD_sig = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic close_frame(input int e0, input int e1);
    if (DEPTH - exp_level >= N_CH) begin
      sb.push_back('{data: CNT_W'(e0), ch: CH_W'(0)});
      sb.push_back('{data: CNT_W'(e1), ch: CH_W'(1)});
      exp_level += N_CH;
    end
    dmd_pulse();
  endtask

  task automatic pop();
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    if (exp_level > 0) exp_level--;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for the first word of a frame to land, i.e. mid-write.
  task automatic wait_level_nonzero(input string name);
    int waited;
    waited = 0;
    while (level == '0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_output(name, (level != '0) ? 1 : 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 1 ms");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tbl[0] = '{1, 2, 1, 2};
    tbl[1] = '{3, 0, 3, 0};
    tbl[2] = '{7, 5, 7, 5};
    tbl[3] = '{0, 9, 0, 9};
    tbl[4] = '{15, 1, 15, 1};
    tbl[5] = '{2, 2, 2, 2};
    tbl[6] = '{4, 6, 4, 6};
    tbl[7] = '{6, 11, 6, 11};
    tbl[8] = '{1, 1, 1, 1};
    tbl[9] = '{10, 3, 10, 3};

    rst = 1'b1; sig = '0; DMD_sig = 1'b0; enable = 1'b0; clear = 1'b0; rd_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("reset_level", int'(level), 0);
    check_output("reset_empty", int'(empty), 1);
    check_output("reset_full", int'(full), 0);
    check_output("reset_overflow", int'(overflow), 0);
    check_output("reset_sat", int'(sat), 0);
    check_output("reset_rd_valid", int'(rd_valid), 0);
    check_output("reset_rd_data", int'(rd_data), 0);

    pop();
    check_output("empty_pop_no_valid", int'(rd_valid), 0);

    // Pulses before the arming edge belong to a partial frame and must vanish.
    enable = 1'b1;
    settle(2);
    apply_stimulus(3, 3);
    dmd_pulse();
    settle(6);
    check_output("arm_no_store", int'(level), 0);

    apply_stimulus(5, 3);
    close_frame(5, 3);
    settle(4);
    check_output("single_level2", int'(level), 2);
    check_output("single_not_empty", int'(empty), 0);
    pop(); pop();
    settle(2);
    check_output("single_level0", int'(level), 0);
    check_output("single_empty", int'(empty), 1);

    apply_stimulus(20, 2);
    close_frame(15, 2);
    settle(4);
    check_output("sat_flag", int'(sat), 1);
    pop(); pop();
    settle(2);

    // Coincident sig[0] and DMD edges: old frame keeps 2, new frame starts at 1.
    apply_stimulus(2, 0);
    sb.push_back('{data: CNT_W'(2), ch: CH_W'(0)});
    sb.push_back('{data: CNT_W'(0), ch: CH_W'(1)});
    exp_level += N_CH;
    sig = 2'b01; DMD_sig = 1'b1;
    repeat (2) @(negedge clk);
    sig = '0; DMD_sig = 1'b0;
    repeat (2) @(negedge clk);
    apply_stimulus(1, 0);
    close_frame(2, 0);
    settle(4);
    check_output("coinc_level", int'(level), 4);
    pop(); pop(); pop(); pop();
    settle(2);
    check_output("coinc_drained", int'(level), 0);
    check_output("coinc_no_overflow", int'(overflow), 0);

    apply_stimulus(1, 2); close_frame(1, 2);
    apply_stimulus(3, 4); close_frame(3, 4);
    apply_stimulus(5, 6); close_frame(5, 6);
    settle(4);
    check_output("full_level", int'(level), 4);
    check_output("full_flag", int'(full), 1);
    check_output("full_overflow", int'(overflow), 1);
    pop();
    apply_stimulus(7, 7); close_frame(7, 7);
    settle(4);
    check_output("partial_free_level", int'(level), 3);
    check_output("partial_free_not_full", int'(full), 0);
    pop(); pop(); pop();
    settle(2);
    check_output("full_drained", int'(level), 0);

    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_output("clear_overflow", int'(overflow), 0);
    check_output("clear_sat", int'(sat), 0);
    check_output("clear_empty", int'(empty), 1);
    settle(2);
    dmd_pulse();
    settle(6);

    // Pops of frame k-1 overlap the writes of frame k, wrapping both pointers.
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(tbl[k].n0, tbl[k].n1);
      close_frame(tbl[k].e0, tbl[k].e1);
      if (k > 0) begin
        pop(); pop();
      end
      settle(2);
    end
    settle(4);
    pop(); pop();
    settle(2);
    check_output("wrap_level0", int'(level), 0);
    check_output("wrap_no_overflow", int'(overflow), 0);
    check_output("wrap_sb_empty", sb.size(), 0);

    apply_stimulus(4, 9);
    sb.push_back('{data: CNT_W'(4), ch: CH_W'(0)});
    sb.push_back('{data: CNT_W'(9), ch: CH_W'(1)});
    exp_level += N_CH;
    DMD_sig = 1'b1;
    repeat (2) @(negedge clk);
    DMD_sig = 1'b0;
    wait_level_nonzero("en_low_write_started");
    enable = 1'b0;
    settle(4);
    check_output("en_low_whole_frame", int'(level), 2);
    apply_stimulus(3, 3);
    dmd_pulse();
    settle(6);
    check_output("en_low_idle_ignores", int'(level), 2);
    pop(); pop();
    settle(2);

    enable = 1'b1;
    settle(2);
    dmd_pulse();
    settle(6);
    apply_stimulus(20, 1);
    check_output("pre_rst_sat", int'(sat), 1);
    DMD_sig = 1'b1;
    repeat (2) @(negedge clk);
    DMD_sig = 1'b0;
    wait_level_nonzero("rst_write_started");
    rst = 1'b1;
    #3;
    rst = 1'b0;
    exp_level = 0;
    @(negedge clk);
    check_output("rst_level", int'(level), 0);
    check_output("rst_empty", int'(empty), 1);
    check_output("rst_sat", int'(sat), 0);
    check_output("rst_overflow", int'(overflow), 0);
    check_output("rst_full", int'(full), 0);
    settle(6);
    check_output("rst_no_partial", int'(level), 0);
    check_output("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
